// File: rtl/debug_pkg.sv
// Shared debugger definitions: command codes, NAK byte, decoder FSM states
// and helpers that size command payloads and replies.
package debug_pkg;

   localparam logic [3:0] FN_HALT     = 4'h1;
   localparam logic [3:0] FN_RESUME   = 4'h2;
   localparam logic [3:0] FN_STEP     = 4'h3;
   localparam logic [3:0] FN_RESET    = 4'h4;
   localparam logic [3:0] FN_RD_PC    = 4'h5;
   localparam logic [3:0] FN_RD_BYTE  = 4'h6;
   localparam logic [3:0] FN_RD_WORD  = 4'h7;
   localparam logic [3:0] FN_RD_REG   = 4'h8;
   localparam logic [3:0] FN_SET_BP   = 4'h9;
   localparam logic [3:0] FN_CLR_BP   = 4'hA;
   localparam logic [3:0] FN_WR_BYTE  = 4'hB;
   localparam logic [3:0] FN_WR_WORD  = 4'hC;
   localparam logic [3:0] FN_WR_REG   = 4'hD;

   localparam logic [7:0] NAK_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DATA,
      S_PRE,
      S_ISSUE,
      S_GUARD,
      S_WAIT,
      S_REPLY
   } sdec_state_e;

   function automatic logic cmd_known(input logic [3:0] code);
      return (code >= FN_HALT) && (code <= FN_WR_REG);
   endfunction

   // Payload bytes following the command byte: 0, 4 (addr) or 8 (addr + data).
   function automatic logic [3:0] payload_len(input logic [3:0] code);
      if ((code >= FN_RD_BYTE) && (code <= FN_CLR_BP))
         return 4'd4;
      else if ((code >= FN_WR_BYTE) && (code <= FN_WR_REG))
         return 4'd8;
      else
         return 4'd0;
   endfunction

   function automatic logic [2:0] reply_len(input logic [3:0] code);
      if ((code == FN_RD_PC) || (code == FN_RD_WORD) || (code == FN_RD_REG))
         return 3'd4;
      else
         return 3'd1;
   endfunction

endpackage

// File: rtl/shift_assembler.sv
// Assembles a 32-bit word from four bytes arriving MSB first; done flags the
// cycle in which the fourth byte is being shifted in.
module shift_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] value,
   output logic        done
);

   logic [1:0] count;

   // The value is kept after a frame so the controller can keep re-reading it.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= 32'h0;
         count <= 2'd0;
      end else if (clear) begin
         count <= 2'd0;
      end else if (shift_en) begin
         value <= {value[23:0], byte_in};
         count <= count + 2'd1;
      end
   end

   assign done = shift_en && (count == 2'd3);

endmodule

// File: rtl/serial_cmd_decoder.sv
// Turns UART RX bytes into controller commands and sends replies back over TX.
// Define SDEC_RX_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES of silence.
import debug_pkg::*;

module serial_cmd_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [3:0]  cmd,
   output logic [31:0] addr,
   output logic [31:0] wr_data,
   output logic        in_valid,
   input  logic        ctrlr_busy,
   input  logic [31:0] rd_data,
   output logic        frame_err
);

   sdec_state_e state, next_state;

   logic        frame_start, bad_cmd, drop_byte;
   logic        addr_shift, data_shift, addr_done, data_done;
   logic        timeout_hit;
   logic [31:0] reply_reg;
   logic [1:0]  reply_left;
   logic [7:0]  lane_byte;

   assign frame_start = (state == S_CMD) && rx_valid;
   assign bad_cmd     = frame_start && !cmd_known(rx_data[3:0]);
   assign addr_shift  = (state == S_ADDR) && rx_valid;
   assign data_shift  = (state == S_DATA) && rx_valid;
   assign drop_byte   = rx_valid && !(state inside {S_CMD, S_ADDR, S_DATA});
   assign lane_byte   = 8'(rd_data >> {addr[1:0], 3'b000});
   assign tx_data     = reply_reg[31:24];

   shift_assembler u_addr_asm (
      .clk      (clk),
      .rst      (rst),
      .clear    (frame_start),
      .shift_en (addr_shift),
      .byte_in  (rx_data),
      .value    (addr),
      .done     (addr_done)
   );

   shift_assembler u_data_asm (
      .clk      (clk),
      .rst      (rst),
      .clear    (frame_start),
      .shift_en (data_shift),
      .byte_in  (rx_data),
      .value    (wr_data),
      .done     (data_done)
   );

`ifdef SDEC_RX_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Counts silent cycles while a frame payload is in progress.
   always_ff @(posedge clk) begin
      if (rst || rx_valid || !(state inside {S_ADDR, S_DATA}))
         idle_cnt <= 32'h0;
      else
         idle_cnt <= idle_cnt + 32'h1;
   end

   assign timeout_hit = (state inside {S_ADDR, S_DATA}) && !rx_valid &&
                        (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_CMD;
      else
         state <= next_state;
   end

   // in_valid and tx_valid depend only on the registered state, because the
   // controller's busy reacts combinationally to in_valid.
   always_comb begin
      next_state = state;
      in_valid   = 1'b0;
      tx_valid   = 1'b0;
      case (state)
         S_CMD: begin
            if (rx_valid) begin
               if (!cmd_known(rx_data[3:0]))
                  next_state = S_REPLY;
               else if (payload_len(rx_data[3:0]) == 4'd0)
                  next_state = S_PRE;
               else
                  next_state = S_ADDR;
            end
         end
         S_ADDR: begin
            if (timeout_hit)
               next_state = S_CMD;
            else if (addr_done)
               next_state = (payload_len(cmd) == 4'd8) ? S_DATA : S_PRE;
         end
         S_DATA: begin
            if (timeout_hit)
               next_state = S_CMD;
            else if (data_done)
               next_state = S_PRE;
         end
         S_PRE: begin
            if (!ctrlr_busy)
               next_state = S_ISSUE;
         end
         S_ISSUE: begin
            in_valid   = 1'b1;
            next_state = S_GUARD;
         end
         S_GUARD: next_state = S_WAIT;
         S_WAIT: begin
            if (!ctrlr_busy)
               next_state = S_REPLY;
         end
         S_REPLY: begin
            tx_valid = 1'b1;
            if (tx_ready && (reply_left == 2'd0))
               next_state = S_CMD;
         end
         default: next_state = S_CMD;
      endcase
   end

   // Reply bytes are always taken from the top of reply_reg and shifted out.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd        <= 4'h0;
         reply_reg  <= 32'h0;
         reply_left <= 2'd0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= drop_byte || bad_cmd || timeout_hit;
         if (frame_start)
            cmd <= rx_data[3:0];
         if (bad_cmd) begin
            reply_reg  <= {NAK_BYTE, 24'h0};
            reply_left <= 2'd0;
         end
         if ((state == S_WAIT) && !ctrlr_busy) begin
            reply_left <= 2'(reply_len(cmd) - 3'd1);
            if (reply_len(cmd) == 3'd4)
               reply_reg <= rd_data;
            else if (cmd == FN_RD_BYTE)
               reply_reg <= {lane_byte, 24'h0};
            else
               reply_reg <= {4'h0, cmd, 24'h0};
         end
         if (tx_valid && tx_ready) begin
            reply_reg  <= {reply_reg[23:0], 8'h0};
            reply_left <= reply_left - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Bench for serial_cmd_decoder: frame-level model of issued commands and reply
// bytes, a small controller model, and a per-cycle compare process.
module tb_serial_cmd_decoder;

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          has_addr;
      bit          has_data;
   } issue_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        in_valid;
   logic        ctrlr_busy;
   logic [31:0] rd_data;
   logic        frame_err;

   logic        busy_q = 1'b0;
   logic        hold_busy = 1'b0;
   logic        busy_on_strobe = 1'b1;
   int          busy_len = 3;
   int          busy_cnt = 0;
   logic [31:0] rd_value = 32'h0;

   int          total_checks = 0;
   int          passed_checks = 0;
   int          err_seen = 0;
   int          err_expected = 0;
   int          issue_seen = 0;
   issue_t      exp_issue[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  obs_tx[$];
   issue_t      cur_op;
   bit          in_op = 1'b0;
   logic        prev_busy = 1'b0;
   logic [3:0]  last_cmd = 4'h0;
   logic [31:0] last_addr = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   assign ctrlr_busy = busy_q | hold_busy | (in_valid & busy_on_strobe);
   assign rd_data    = rd_value;

   always #5 clk = ~clk;

   serial_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .cmd        (cmd),
      .addr       (addr),
      .wr_data    (wr_data),
      .in_valid   (in_valid),
      .ctrlr_busy (ctrlr_busy),
      .rd_data    (rd_data),
      .frame_err  (frame_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total_checks++;
      if (actual === expected)
         passed_checks++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic logic [31:0] obs_word();
      logic [31:0] w = 32'h0;
      for (int i = 0; i < 4; i++)
         w = {w[23:0], (i < obs_tx.size()) ? obs_tx[i] : 8'h00};
      return w;
   endfunction

   // Controller: busy for busy_len cycles after each strobe.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            busy_cnt = 0;
         end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (in_valid) busy_cnt = busy_len;
         end
         busy_q = (busy_cnt > 0);
      end
   end

   // Compare process: strobes, held command fields, TX bytes, error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_seen++;
         if (in_valid) begin
            issue_seen++;
            last_cmd   = cmd;
            last_addr  = addr;
            last_wdata = wr_data;
            checkOutput("issue_while_busy", {31'h0, prev_busy}, 32'h0);
            if (exp_issue.size() == 0) begin
               checkOutput("unexpected_issue", 32'h1, 32'h0);
            end else begin
               cur_op = exp_issue.pop_front();
               in_op  = 1'b1;
               checkOutput("issue_cmd", {28'h0, cmd}, {28'h0, cur_op.cmd});
               if (cur_op.has_addr) checkOutput("issue_addr", addr, cur_op.addr);
               if (cur_op.has_data) checkOutput("issue_wr_data", wr_data, cur_op.wdata);
            end
         end else if (in_op) begin
            if (tx_valid) begin
               in_op = 1'b0;
            end else begin
               checkOutput("hold_cmd", {28'h0, cmd}, {28'h0, cur_op.cmd});
               if (cur_op.has_addr) checkOutput("hold_addr", addr, cur_op.addr);
            end
         end
         if (tx_valid && tx_ready) begin
            obs_tx.push_back(tx_data);
            if (exp_tx.size() == 0)
               checkOutput("unexpected_tx", {24'h0, tx_data}, 32'h100);
            else
               checkOutput("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
         end
      end
      prev_busy = ctrlr_busy;
   end

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h0;
   endtask

   // Model of a whole frame from the protocol rules, then the bytes on the wire.
   task automatic applyStimulus(input logic [7:0] frame [9], input int len);
      logic [3:0]  code = frame[0][3:0];
      logic [31:0] a    = {frame[1], frame[2], frame[3], frame[4]};
      logic [31:0] d    = {frame[5], frame[6], frame[7], frame[8]};
      issue_t      e;
      if (code == 4'h0 || code >= 4'hE) begin
         exp_tx.push_back(8'hFF);
         err_expected++;
      end else begin
         e.cmd      = code;
         e.addr     = a;
         e.wdata    = d;
         e.has_addr = (code >= 4'h6);
         e.has_data = (code >= 4'hB);
         exp_issue.push_back(e);
         if (code == 4'h5 || code == 4'h7 || code == 4'h8) begin
            for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(rd_value >> (8 * i)));
         end else if (code == 4'h6) begin
            exp_tx.push_back(8'(rd_value >> (8 * a[1:0])));
         end else begin
            exp_tx.push_back({4'h0, code});
         end
      end
      for (int i = 0; i < len; i++) sendByte(frame[i]);
   endtask

   task automatic waitIdle();
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (exp_tx.size() == 0 && exp_issue.size() == 0 && !tx_valid) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput("wait_idle", {31'h0, done}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("frame_err_count", err_seen, err_expected);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      checkOutput("reset_tx_data", {24'h0, tx_data}, 32'h0);
      checkOutput("reset_in_valid", {31'h0, in_valid}, 32'h0);
      checkOutput("reset_frame_err", {31'h0, frame_err}, 32'h0);
      checkOutput("reset_cmd", {28'h0, cmd}, 32'h0);
      checkOutput("reset_addr", addr, 32'h0);
      checkOutput("reset_wr_data", wr_data, 32'h0);

      $display("[TB] read word, busy 3 cycles");
      rd_value = 32'hDEADBEEF;
      obs_tx.delete();
      base = issue_seen;
      applyStimulus('{8'h07, 8'h00, 8'h00, 8'h10, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
      waitIdle();
      checkOutput("rdword_issues", issue_seen - base, 32'd1);
      checkOutput("rdword_cmd", {28'h0, last_cmd}, 32'h7);
      checkOutput("rdword_addr", last_addr, 32'h00001004);
      checkOutput("rdword_tx_count", obs_tx.size(), 32'd4);
      checkOutput("rdword_tx_word", obs_word(), 32'hDEADBEEF);

      $display("[TB] write word");
      obs_tx.delete();
      applyStimulus('{8'h0C, 8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78}, 9);
      waitIdle();
      checkOutput("wrword_wr_data", last_wdata, 32'h12345678);
      checkOutput("wrword_addr", last_addr, 32'h00000020);
      checkOutput("wrword_tx_count", obs_tx.size(), 32'd1);
      checkOutput("wrword_tx", {24'h0, obs_tx[0]}, 32'h0C);

      $display("[TB] busy drops with the strobe");
      busy_len = 0;
      obs_tx.delete();
      base = issue_seen;
      applyStimulus('{8'h09, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
      waitIdle();
      checkOutput("guard_issues", issue_seen - base, 32'd1);
      checkOutput("guard_tx_count", obs_tx.size(), 32'd1);
      checkOutput("guard_tx", {24'h0, obs_tx[0]}, 32'h09);
      busy_len = 3;

      $display("[TB] controller paused before frame completes");
      obs_tx.delete();
      base = issue_seen;
      hold_busy = 1'b1;
      applyStimulus('{8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("pause_cmd", {28'h0, cmd}, 32'hA);
         checkOutput("pause_addr", addr, 32'h00000005);
      end
      checkOutput("pause_no_issue", issue_seen - base, 32'd0);
      hold_busy = 1'b0;
      waitIdle();
      checkOutput("pause_issues", issue_seen - base, 32'd1);
      checkOutput("pause_tx", {24'h0, obs_tx[0]}, 32'h0A);

      $display("[TB] unknown code and dropped byte");
      obs_tx.delete();
      base = issue_seen;
      tx_ready = 1'b0;
      applyStimulus('{8'h0E, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      repeat (2) @(posedge clk);
      #1;
      sendByte(8'h55);
      err_expected++;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("nak_err_pulses", err_seen - (err_expected - 2), 32'd2);
      tx_ready = 1'b1;
      waitIdle();
      checkOutput("nak_no_issue", issue_seen - base, 32'd0);
      checkOutput("nak_tx_count", obs_tx.size(), 32'd1);
      checkOutput("nak_tx", {24'h0, obs_tx[0]}, 32'hFF);

      $display("[TB] byte lane read and no-payload commands");
      rd_value = 32'hAABBCCDD;
      obs_tx.delete();
      applyStimulus('{8'h06, 8'h00, 8'h00, 8'h00, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
      waitIdle();
      checkOutput("lane_tx", {24'h0, obs_tx[0]}, 32'hBB);
      rd_value = 32'h01020304;
      obs_tx.delete();
      applyStimulus('{8'h15, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      waitIdle();
      checkOutput("rdpc_tx_word", obs_word(), 32'h01020304);
      checkOutput("rdpc_cmd", {28'h0, last_cmd}, 32'h5);
      obs_tx.delete();
      applyStimulus('{8'h03, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      waitIdle();
      checkOutput("step_tx", {24'h0, obs_tx[0]}, 32'h03);

`ifdef SDEC_RX_TIMEOUT_EN
      $display("[TB] inter-byte timeout");
      obs_tx.delete();
      base = issue_seen;
      sendByte(8'h06);
      sendByte(8'h00);
      err_expected++;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("timeout_err", err_seen, err_expected);
      checkOutput("timeout_no_issue", issue_seen - base, 32'd0);
      checkOutput("timeout_no_tx", obs_tx.size(), 32'd0);
      applyStimulus('{8'h0A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
      waitIdle();
      checkOutput("after_timeout_addr", last_addr, 32'h00000003);
      checkOutput("after_timeout_tx", {24'h0, obs_tx[0]}, 32'h0A);
`endif

      checkOutput("issue_queue_empty", exp_issue.size(), 32'd0);
      checkOutput("tx_queue_empty", exp_tx.size(), 32'd0);
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/serial_cmd_decoder.md
Name: serial_cmd_decoder

Overview:
- Upstream neighbour of the debugger controller FSM.
- Assembles command frames from the UART RX byte stream.
- Presents cmd/addr/wr_data to the controller with a one-cycle in_valid, waits for the controller to finish, then returns an ack or read data to the UART TX byte stream.
- Sole bridge between the host client protocol and the controller.

Parameters:
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles. Used only with SDEC_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART RX
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  UART TX accepts byte when tx_valid&&tx_ready
- cmd  out  4  command code to controller
- addr  out  32  address / register index / breakpoint index to controller
- wr_data  out  32  write data to MCU debug port
- in_valid  out  1  one-cycle command strobe to controller
- ctrlr_busy  in  1  controller busy
- rd_data  in  32  read result from MCU debug port
- frame_err  out  1  one-cycle pulse: dropped byte, unknown command or timeout

Behaviour:
- Reset values: all outputs 0, state S_CMD, byte counter 0.
- Reset mid-frame or mid-wait returns to S_CMD. An outstanding controller operation is not cancelled.
- Frame format: command byte (low nibble = code, high nibble ignored), then payload, all multi-byte fields MSB first.
- Payload by code:
  - 0x1–0x5: none.
  - 0x6, 0x7, 0x8, 0x9, 0xA: 4 addr bytes.
  - 0xB, 0xC, 0xD: 4 addr bytes + 4 data bytes.
- Codes 0x0, 0xE, 0xF: not issued; reply 0xFF; frame_err pulse.
- States:
  - S_CMD: on rx_valid, latch cmd, reset counter. Go to S_ADDR / S_PRE or S_REPLY (unknown code).
  - S_ADDR: shift rx_data into addr on each rx_valid. After 4th byte go to S_DATA (write codes) else S_PRE.
  - S_DATA: same, into wr_data. After 4th byte go to S_PRE.
  - S_PRE: stay while ctrlr_busy=1; go to S_ISSUE when ctrlr_busy=0.
  - S_ISSUE: in_valid=1 for exactly this one cycle; go to S_GUARD.
  - S_GUARD: one cycle, ctrlr_busy ignored (controller may drop busy same cycle as strobe); go to S_WAIT.
  - S_WAIT: stay while ctrlr_busy=1. On ctrlr_busy=0, capture rd_data into reply register; go to S_REPLY.
  - S_REPLY: drive tx_valid with current reply byte; advance on handshake. After last byte go to S_CMD.
- in_valid is decoded from registered state only. No combinational path from ctrlr_busy to in_valid (controller's busy is combinational on in_valid).
- cmd, addr, wr_data held stable from S_ISSUE through S_WAIT; the controller re-reads cmd/addr in its wait states.
- Replies:
  - 0x7, 0x8, 0x5: 4 bytes of captured rd_data, MSB first.
  - 0x6: 1 byte, rd_data byte lane addr[1:0] (lane 0 = bits 7:0).
  - All others: 1 byte echo {4'h0, cmd}.
- rx_valid outside S_CMD/S_ADDR/S_DATA: byte dropped, frame_err pulses next cycle, state unchanged.
- Counter is 2 bits and wraps; the 4th byte is detected at count 3.

Optional Feature:
- Macro SDEC_RX_TIMEOUT_EN.
- Defined: a cycle counter runs in S_ADDR/S_DATA and clears on each rx_valid. On reaching TIMEOUT_CYCLES-1 the partial frame is discarded, state goes to S_CMD and frame_err pulses. Nothing is issued and nothing is transmitted.
- Undefined: counter absent; partial frames wait indefinitely.

Decomposition:
- Shared package debug_pkg: FN_* command codes (shared with the controller), NAK byte 0xFF, payload-length function of cmd, reply-length function of cmd.
- Natural sub-module: shift_assembler (4-byte MSB-first shift register with byte counter and done flag), instantiated for addr and wr_data.

Test Plan:
- RX 0x07,0x00,0x00,0x10,0x04; controller model busy 3 cycles, rd_data=0xDEADBEEF -> one in_valid, cmd=7, addr=0x00001004; TX DE,AD,BE,EF.
- RX 0x0C, addr 0x00000020, data 0x12345678 -> in_valid once with wr_data=0x12345678; TX 0x0C after busy falls.
- RX 0x09 + addr 0x00000100, controller drops busy same cycle as in_valid -> S_GUARD covers it; TX 0x09 exactly once, no second in_valid.
- ctrlr_busy=1 held 10 cycles before frame completes (breakpoint pause), then 0 -> in_valid only after busy low; cmd/addr stable throughout.
- RX 0x0E; then byte during S_REPLY with tx_ready=0 -> TX 0xFF, frame_err pulses twice, no in_valid.
- With SDEC_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: RX 0x06,0x00 then silence 16 cycles -> frame_err pulse, S_CMD; next full frame decodes correctly.
